banked_regfile: RTL and testbench
=================================

# banked_regfile

Parametrised banked register file for the ARMv4 core, successor to the two-bank IRQ register file. It provides NUM_MODES register banks for the upper registers and a small state machine that enters and returns from exception modes. On entry it saves the return address into the target bank's r14 and records the previous mode; on return it restores that mode. It sits between decode (read ports) and the EX/WB stages (write ports) and drives PC redirects for writes to r15.

## Interface
- DATA_W, 32, register width
- NUM_MODES, 4, number of processor modes/banks (mode 0 = user, ≥2)
- MODE_W, 2, mode index width, $clog2(NUM_MODES)
- BANK_BASE, 13, first banked register; r[BANK_BASE..14] are per-mode, r[0..BANK_BASE-1] shared, 1..14
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  stage enable; when 0 nothing commits and FSM holds
- i_rm_code, i_rn_code, i_rs_code, i_re_code  in  4 each  read addresses
- o_rm_reg, o_rn_reg, o_rs_reg, o_re_reg  out  DATA_W each  read data, combinational
- i_pc_next  in  DATA_W  value returned for reads of r15
- i_rd_en_ex, i_rd_code_ex, i_rd_reg_ex  in  1/4/DATA_W  EX write port
- i_rd_en_wb, i_rd_code_wb, i_rd_reg_wb  in  1/4/DATA_W  WB write port
- o_pc_en  out  1  a write to r15 is present (combinational)
- o_pc_reg  out  DATA_W  PC redirect value (combinational)
- i_exc_req  in  1  exception entry request
- i_exc_mode  in  MODE_W  target mode of entry
- i_exc_ret_addr  in  DATA_W  return address to store in target bank r14
- i_exc_ret  in  1  exception return request
- o_exc_ack  out  1  one-cycle pulse, request accepted
- o_exc_err  out  1  one-cycle pulse, request rejected
- o_busy  out  1  FSM in ENTER or RET
- o_mode  out  MODE_W  current mode

## Operation
- Read r<BANK_BASE: shared register. Reads BANK_BASE..14 use the bank[o_mode] copy. Reads of r15 return i_pc_next. No write-to-read bypass.
- Writes for codes 0..14 commit on the clock edge when en=1, into the bank of o_mode at that edge. When EX and WB target the same code, EX wins.
- o_pc_en = (ex en & code 15) | (wb en & code 15). o_pc_reg = WB value if WB targets r15, else EX value. Writes to r15 never store.
- FSM states: IDLE, ENTER, RET. Transitions advance only when en=1.
- IDLE + i_exc_req: if i_exc_mode == o_mode or i_exc_mode ≥ NUM_MODES, pulse o_exc_err and stay IDLE. Otherwise pulse o_exc_ack, capture mode and address into staging registers, go to ENTER.
- IDLE + i_exc_ret (no req): if o_mode == 0, pulse o_exc_err. Otherwise pulse o_exc_ack and go to RET.
- If req and ret are asserted together, req has priority and ret is ignored.
- ENTER, one en cycle: pipeline writes still go to the old bank. At the end edge: bank[new].r14 ← staged address, saved_mode[new] ← old mode, o_mode ← new, go to IDLE.
- RET, one en cycle: at the end edge, o_mode ← saved_mode[o_mode], go to IDLE.
- Requests while o_busy=1 are ignored, with no ack and no err. The requester holds the request until it sees ack or err.
- Reset: all registers, all banks, and saved_mode are cleared to 0. o_mode=0, state IDLE, o_busy=0, o_exc_ack=0, o_exc_err=0. Reset overrides en and any mid-ENTER/RET operation.

## Timing
- Read latency is 0 cycles (combinational). A write is visible on the read port in the cycle after its edge.
- Entry: request in cycle N, ack registered (visible in N+1), o_busy=1 in N+1, new o_mode visible in N+2.
- Return: same as entry; the restored mode is visible in N+2.
- o_exc_ack and o_exc_err are registered, 1 cycle wide. They are never both high.
- While en=0, all state and outputs hold, and ack/err deassert.

## Test plan
- Reset, then write r3=0x11 via EX and r3=0x22 via WB in the same cycle -> r3 reads 0x11. Any r15 read returns i_pc_next.
- WB writes r15=0x100 while EX writes r15=0x200 -> o_pc_en=1, o_pc_reg=0x100, no register changes.
- Mode 0: write r13=0xA. Request entry to mode 2 with ret_addr 0x40 -> ack at N+1, o_mode=2 at N+2, r14 reads 0x40, r13 reads 0 (banked). r12 written earlier is still visible.
- Inside mode 2, request entry to mode 2 -> o_exc_err pulse, mode unchanged. Enter mode 1, then return -> mode 2. Return again -> mode 0, r13 reads 0xA.
- Return in mode 0 -> err. Req and ret asserted together -> entry taken. Request during o_busy -> no ack/err. With en=0 for 3 cycles mid-ENTER, state holds, then completes.
- Assert rst in the ENTER cycle -> next cycle o_mode=0, o_busy=0, all reads 0 except r15.

Source files
------------

// File: rtl/banked_regfile.sv
// banked_regfile: register file with per-mode banks for r[BANK_BASE..14]
// and an exception entry/return state machine.
//
// Ports:
//   clk, rst, en                  clock, sync active-high reset, stage enable
//   i_r{m,n,s,e}_code / o_r*_reg  four combinational read ports (r15 -> i_pc_next)
//   i_pc_next                     value returned for reads of r15
//   i_rd_*_ex, i_rd_*_wb          EX / WB write ports (EX wins on same code)
//   o_pc_en, o_pc_reg             PC redirect for writes targeting r15
//   i_exc_req/_mode/_ret_addr     exception entry request
//   i_exc_ret                     exception return request
//   o_exc_ack, o_exc_err          registered one-cycle accept / reject pulses
//   o_busy, o_mode                FSM in ENTER/RET, current mode
module banked_regfile #(
    parameter int DATA_W    = 32,
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2,
    parameter int BANK_BASE = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        i_rm_code,
    input  logic [3:0]        i_rn_code,
    input  logic [3:0]        i_rs_code,
    input  logic [3:0]        i_re_code,
    output logic [DATA_W-1:0] o_rm_reg,
    output logic [DATA_W-1:0] o_rn_reg,
    output logic [DATA_W-1:0] o_rs_reg,
    output logic [DATA_W-1:0] o_re_reg,
    input  logic [DATA_W-1:0] i_pc_next,
    input  logic              i_rd_en_ex,
    input  logic [3:0]        i_rd_code_ex,
    input  logic [DATA_W-1:0] i_rd_reg_ex,
    input  logic              i_rd_en_wb,
    input  logic [3:0]        i_rd_code_wb,
    input  logic [DATA_W-1:0] i_rd_reg_wb,
    output logic              o_pc_en,
    output logic [DATA_W-1:0] o_pc_reg,
    input  logic              i_exc_req,
    input  logic [MODE_W-1:0] i_exc_mode,
    input  logic [DATA_W-1:0] i_exc_ret_addr,
    input  logic              i_exc_ret,
    output logic              o_exc_ack,
    output logic              o_exc_err,
    output logic              o_busy,
    output logic [MODE_W-1:0] o_mode
);

    localparam int NBANK = 15 - BANK_BASE;

    typedef enum logic [1:0] {S_IDLE, S_ENTER, S_RET} state_t;

    logic [DATA_W-1:0] r_shared [BANK_BASE];
    logic [DATA_W-1:0] r_bank   [NUM_MODES][NBANK];
    logic [MODE_W-1:0] r_saved  [NUM_MODES];

    state_t            r_state, w_state_nxt;
    logic [MODE_W-1:0] r_mode, r_stg_mode, w_ret_mode;
    logic [DATA_W-1:0] r_stg_addr;
    logic              r_ack, r_err;
    logic              w_ack_nxt, w_err_nxt, w_capture, w_mode_bad;

    // Address decode is done by loop-compare rather than direct indexing so
    // that the 4-bit codes never index narrower arrays out of range.
    function automatic logic [DATA_W-1:0] f_read(input logic [3:0] code);
        f_read = '0;
        if (code == 4'd15)
            f_read = i_pc_next;
        for (int unsigned k = 0; k < BANK_BASE; k++)
            if (code == 4'(k))
                f_read = r_shared[k];
        for (int unsigned m = 0; m < NUM_MODES; m++)
            for (int unsigned k = 0; k < NBANK; k++)
                if (r_mode == MODE_W'(m) && code == 4'(BANK_BASE + k))
                    f_read = r_bank[m][k];
    endfunction

    always_comb begin
        o_rm_reg = f_read(i_rm_code);
        o_rn_reg = f_read(i_rn_code);
        o_rs_reg = f_read(i_rs_code);
        o_re_reg = f_read(i_re_code);
    end

    assign o_pc_en   = (i_rd_en_ex && i_rd_code_ex == 4'd15) ||
                       (i_rd_en_wb && i_rd_code_wb == 4'd15);
    assign o_pc_reg  = (i_rd_en_wb && i_rd_code_wb == 4'd15) ? i_rd_reg_wb : i_rd_reg_ex;
    assign o_exc_ack = r_ack;
    assign o_exc_err = r_err;
    assign o_busy    = (r_state != S_IDLE);
    assign o_mode    = r_mode;

    assign w_mode_bad = (i_exc_mode == r_mode) ||
                        ({1'b0, i_exc_mode} >= (MODE_W+1)'(NUM_MODES));

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_capture   = 1'b0;
        w_ret_mode  = '0;
        for (int unsigned m = 0; m < NUM_MODES; m++)
            if (r_mode == MODE_W'(m))
                w_ret_mode = r_saved[m];
        case (r_state)
            S_IDLE: begin
                if (i_exc_req) begin
                    if (w_mode_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_ack_nxt   = 1'b1;
                        w_capture   = 1'b1;
                        w_state_nxt = S_ENTER;
                    end
                end else if (i_exc_ret) begin
                    if (r_mode == '0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = S_RET;
                    end
                end
            end
            S_ENTER, S_RET: w_state_nxt = S_IDLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= '0;
            r_stg_mode <= '0;
            r_stg_addr <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            for (int unsigned k = 0; k < BANK_BASE; k++)
                r_shared[k] <= '0;
            for (int unsigned m = 0; m < NUM_MODES; m++) begin
                r_saved[m] <= '0;
                for (int unsigned k = 0; k < NBANK; k++)
                    r_bank[m][k] <= '0;
            end
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (en) begin
                r_state <= w_state_nxt;
                r_ack   <= w_ack_nxt;
                r_err   <= w_err_nxt;
                if (w_capture) begin
                    r_stg_mode <= i_exc_mode;
                    r_stg_addr <= i_exc_ret_addr;
                end
                // WB is applied before EX so that EX overrides on a shared code.
                for (int unsigned k = 0; k < BANK_BASE; k++) begin
                    if (i_rd_en_wb && i_rd_code_wb == 4'(k)) r_shared[k] <= i_rd_reg_wb;
                    if (i_rd_en_ex && i_rd_code_ex == 4'(k)) r_shared[k] <= i_rd_reg_ex;
                end
                for (int unsigned m = 0; m < NUM_MODES; m++)
                    for (int unsigned k = 0; k < NBANK; k++)
                        if (r_mode == MODE_W'(m)) begin
                            if (i_rd_en_wb && i_rd_code_wb == 4'(BANK_BASE + k))
                                r_bank[m][k] <= i_rd_reg_wb;
                            if (i_rd_en_ex && i_rd_code_ex == 4'(BANK_BASE + k))
                                r_bank[m][k] <= i_rd_reg_ex;
                        end
                // Pipeline writes above target the old bank; the staged mode
                // always differs from it, so the r14 save cannot collide.
                if (r_state == S_ENTER) begin
                    r_mode <= r_stg_mode;
                    for (int unsigned m = 0; m < NUM_MODES; m++)
                        if (r_stg_mode == MODE_W'(m)) begin
                            r_bank[m][NBANK-1] <= r_stg_addr;
                            r_saved[m]         <= r_mode;
                        end
                end
                if (r_state == S_RET)
                    r_mode <= w_ret_mode;
            end
        end
    end

endmodule

// File: tb/tb_banked_regfile.sv
module tb_banked_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [3:0]  i_rm_code = '0, i_rn_code = '0, i_rs_code = '0, i_re_code = '0;
    logic [31:0] o_rm_reg, o_rn_reg, o_rs_reg, o_re_reg;
    logic [31:0] i_pc_next = 32'hCAFE_0000;
    logic        i_rd_en_ex = 1'b0, i_rd_en_wb = 1'b0;
    logic [3:0]  i_rd_code_ex = '0, i_rd_code_wb = '0;
    logic [31:0] i_rd_reg_ex = '0, i_rd_reg_wb = '0;
    logic        o_pc_en;
    logic [31:0] o_pc_reg;
    logic        i_exc_req = 1'b0, i_exc_ret = 1'b0;
    logic [1:0]  i_exc_mode = '0;
    logic [31:0] i_exc_ret_addr = '0;
    logic        o_exc_ack, o_exc_err, o_busy;
    logic [1:0]  o_mode;

    int pass_cnt  = 0;
    int total_cnt = 0;

    banked_regfile #(.DATA_W(32), .NUM_MODES(4), .MODE_W(2), .BANK_BASE(13)) dut (
        .clk(clk), .rst(rst), .en(en),
        .i_rm_code(i_rm_code), .i_rn_code(i_rn_code), .i_rs_code(i_rs_code), .i_re_code(i_re_code),
        .o_rm_reg(o_rm_reg), .o_rn_reg(o_rn_reg), .o_rs_reg(o_rs_reg), .o_re_reg(o_re_reg),
        .i_pc_next(i_pc_next),
        .i_rd_en_ex(i_rd_en_ex), .i_rd_code_ex(i_rd_code_ex), .i_rd_reg_ex(i_rd_reg_ex),
        .i_rd_en_wb(i_rd_en_wb), .i_rd_code_wb(i_rd_code_wb), .i_rd_reg_wb(i_rd_reg_wb),
        .o_pc_en(o_pc_en), .o_pc_reg(o_pc_reg),
        .i_exc_req(i_exc_req), .i_exc_mode(i_exc_mode), .i_exc_ret_addr(i_exc_ret_addr),
        .i_exc_ret(i_exc_ret), .o_exc_ack(o_exc_ack), .o_exc_err(o_exc_err),
        .o_busy(o_busy), .o_mode(o_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reads(input logic [3:0] m, input logic [3:0] n,
                             input logic [3:0] s, input logic [3:0] e);
        i_rm_code = m; i_rn_code = n; i_rs_code = s; i_re_code = e;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total_cnt++; if (o_mode !== 2'd0) $display("FAIL reset_mode: got %0d exp 0", o_mode); else pass_cnt++;
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %0b exp 0", o_busy); else pass_cnt++;
        total_cnt++; if ({o_exc_ack, o_exc_err} !== 2'b00) $display("FAIL reset_ack_err: got %b exp 00", {o_exc_ack, o_exc_err}); else pass_cnt++;
        set_reads(4'd3, 4'd13, 4'd14, 4'd15);
        total_cnt++; if (o_rm_reg !== 32'h0) $display("FAIL reset_r3: got %h exp 0", o_rm_reg); else pass_cnt++;
        total_cnt++; if (o_rn_reg !== 32'h0) $display("FAIL reset_r13: got %h exp 0", o_rn_reg); else pass_cnt++;
        total_cnt++; if (o_rs_reg !== 32'h0) $display("FAIL reset_r14: got %h exp 0", o_rs_reg); else pass_cnt++;
        total_cnt++; if (o_re_reg !== 32'hCAFE_0000) $display("FAIL reset_r15: got %h exp cafe0000", o_re_reg); else pass_cnt++;
    endtask

    task automatic test_write_priority();
        i_rd_en_ex = 1'b1; i_rd_code_ex = 4'd3; i_rd_reg_ex = 32'h11;
        i_rd_en_wb = 1'b1; i_rd_code_wb = 4'd3; i_rd_reg_wb = 32'h22;
        set_reads(4'd3, 4'd3, 4'd3, 4'd3);
        total_cnt++; if (o_rm_reg !== 32'h0) $display("FAIL no_bypass: got %h exp 0", o_rm_reg); else pass_cnt++;
        tick();
        i_rd_code_ex = 4'd1;  i_rd_reg_ex = 32'h1;
        i_rd_code_wb = 4'd12; i_rd_reg_wb = 32'h12C;
        #1;
        total_cnt++; if (o_rm_reg !== 32'h11) $display("FAIL ex_wins: got %h exp 11", o_rm_reg); else pass_cnt++;
        tick();
        i_rd_en_ex = 1'b0; i_rd_en_wb = 1'b0;
        set_reads(4'd12, 4'd1, 4'd3, 4'd15);
        total_cnt++; if (o_rm_reg !== 32'h12C) $display("FAIL wb_r12: got %h exp 12c", o_rm_reg); else pass_cnt++;
        total_cnt++; if (o_rn_reg !== 32'h1) $display("FAIL ex_r1: got %h exp 1", o_rn_reg); else pass_cnt++;
    endtask

    task automatic test_pc_write();
        i_rd_en_ex = 1'b1; i_rd_code_ex = 4'd15; i_rd_reg_ex = 32'h200;
        i_rd_en_wb = 1'b1; i_rd_code_wb = 4'd15; i_rd_reg_wb = 32'h100;
        #1;
        total_cnt++; if (o_pc_en !== 1'b1) $display("FAIL pc_en_both: got %0b exp 1", o_pc_en); else pass_cnt++;
        total_cnt++; if (o_pc_reg !== 32'h100) $display("FAIL pc_reg_wb: got %h exp 100", o_pc_reg); else pass_cnt++;
        tick();
        i_rd_en_wb = 1'b0;
        #1;
        total_cnt++; if (o_pc_reg !== 32'h200) $display("FAIL pc_reg_ex: got %h exp 200", o_pc_reg); else pass_cnt++;
        i_rd_en_ex = 1'b0;
        #1;
        total_cnt++; if (o_pc_en !== 1'b0) $display("FAIL pc_en_idle: got %0b exp 0", o_pc_en); else pass_cnt++;
        set_reads(4'd3, 4'd12, 4'd1, 4'd15);
        total_cnt++; if (o_rm_reg !== 32'h11) $display("FAIL pc_no_store_r3: got %h exp 11", o_rm_reg); else pass_cnt++;
        total_cnt++; if (o_re_reg !== 32'hCAFE_0000) $display("FAIL pc_no_store_r15: got %h exp cafe0000", o_re_reg); else pass_cnt++;
    endtask

    task automatic test_enter();
        i_rd_en_ex = 1'b1; i_rd_code_ex = 4'd13; i_rd_reg_ex = 32'hA;
        tick();
        i_rd_en_ex = 1'b0;
        i_exc_req = 1'b1; i_exc_mode = 2'd2; i_exc_ret_addr = 32'h40;
        tick();
        total_cnt++; if (o_exc_ack !== 1'b1) $display("FAIL enter_ack: got %0b exp 1", o_exc_ack); else pass_cnt++;
        total_cnt++; if (o_busy !== 1'b1) $display("FAIL enter_busy: got %0b exp 1", o_busy); else pass_cnt++;
        total_cnt++; if (o_mode !== 2'd0) $display("FAIL enter_mode_n1: got %0d exp 0", o_mode); else pass_cnt++;
        i_exc_req = 1'b0;
        // write during ENTER lands in the old (user) bank
        i_rd_en_wb = 1'b1; i_rd_code_wb = 4'd14; i_rd_reg_wb = 32'h99;
        tick();
        i_rd_en_wb = 1'b0;
        total_cnt++; if (o_mode !== 2'd2) $display("FAIL enter_mode_n2: got %0d exp 2", o_mode); else pass_cnt++;
        total_cnt++; if ({o_exc_ack, o_busy} !== 2'b00) $display("FAIL enter_done: got %b exp 00", {o_exc_ack, o_busy}); else pass_cnt++;
        set_reads(4'd12, 4'd13, 4'd14, 4'd15);
        total_cnt++; if (o_rm_reg !== 32'h12C) $display("FAIL m2_r12: got %h exp 12c", o_rm_reg); else pass_cnt++;
        total_cnt++; if (o_rn_reg !== 32'h0) $display("FAIL m2_r13: got %h exp 0", o_rn_reg); else pass_cnt++;
        total_cnt++; if (o_rs_reg !== 32'h40) $display("FAIL m2_r14: got %h exp 40", o_rs_reg); else pass_cnt++;
    endtask

    task automatic test_nested();
        i_exc_req = 1'b1; i_exc_mode = 2'd2; i_exc_ret_addr = 32'hEE;
        tick();
        total_cnt++; if ({o_exc_ack, o_exc_err} !== 2'b01) $display("FAIL same_mode_err: got %b exp 01", {o_exc_ack, o_exc_err}); else pass_cnt++;
        i_exc_req = 1'b0;
        tick();
        total_cnt++; if ({o_exc_err, o_mode} !== 3'b0_10) $display("FAIL same_mode_hold: got %b exp 010", {o_exc_err, o_mode}); else pass_cnt++;
        i_exc_req = 1'b1; i_exc_mode = 2'd1; i_exc_ret_addr = 32'h80;
        tick();
        i_exc_req = 1'b0;
        tick();
        set_reads(4'd12, 4'd13, 4'd14, 4'd15);
        total_cnt++; if (o_mode !== 2'd1) $display("FAIL nest_mode1: got %0d exp 1", o_mode); else pass_cnt++;
        total_cnt++; if (o_rs_reg !== 32'h80) $display("FAIL m1_r14: got %h exp 80", o_rs_reg); else pass_cnt++;
        i_exc_ret = 1'b1;
        tick();
        total_cnt++; if ({o_exc_ack, o_busy, o_mode} !== 4'b11_01) $display("FAIL ret1_n1: got %b exp 1101", {o_exc_ack, o_busy, o_mode}); else pass_cnt++;
        i_exc_ret = 1'b0;
        tick();
        #1;
        total_cnt++; if (o_mode !== 2'd2) $display("FAIL ret1_mode: got %0d exp 2", o_mode); else pass_cnt++;
        total_cnt++; if (o_rs_reg !== 32'h40) $display("FAIL ret1_r14: got %h exp 40", o_rs_reg); else pass_cnt++;
        i_exc_ret = 1'b1;
        tick();
        i_exc_ret = 1'b0;
        tick();
        #1;
        total_cnt++; if (o_mode !== 2'd0) $display("FAIL ret2_mode: got %0d exp 0", o_mode); else pass_cnt++;
        total_cnt++; if (o_rn_reg !== 32'hA) $display("FAIL ret2_r13: got %h exp a", o_rn_reg); else pass_cnt++;
        total_cnt++; if (o_rs_reg !== 32'h99) $display("FAIL ret2_r14: got %h exp 99", o_rs_reg); else pass_cnt++;
    endtask

    task automatic test_ret_mode0();
        i_exc_ret = 1'b1;
        tick();
        total_cnt++; if ({o_exc_ack, o_exc_err, o_busy} !== 3'b010) $display("FAIL ret_user_err: got %b exp 010", {o_exc_ack, o_exc_err, o_busy}); else pass_cnt++;
        i_exc_ret = 1'b0;
        tick();
        total_cnt++; if ({o_exc_err, o_mode} !== 3'b0_00) $display("FAIL ret_user_hold: got %b exp 000", {o_exc_err, o_mode}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // req and ret together: entry wins (a return from user mode would error)
        i_exc_req = 1'b1; i_exc_mode = 2'd3; i_exc_ret_addr = 32'h300; i_exc_ret = 1'b1;
        tick();
        total_cnt++; if ({o_exc_ack, o_exc_err} !== 2'b10) $display("FAIL req_ret_prio: got %b exp 10", {o_exc_ack, o_exc_err}); else pass_cnt++;
        // keep requests high while busy: they must be ignored
        i_exc_mode = 2'd1;
        tick();
        total_cnt++; if ({o_exc_ack, o_exc_err} !== 2'b00) $display("FAIL busy_ignore: got %b exp 00", {o_exc_ack, o_exc_err}); else pass_cnt++;
        total_cnt++; if (o_mode !== 2'd3) $display("FAIL prio_mode3: got %0d exp 3", o_mode); else pass_cnt++;
        i_exc_req = 1'b0; i_exc_ret = 1'b0;
        set_reads(4'd14, 4'd13, 4'd14, 4'd15);
        total_cnt++; if (o_rm_reg !== 32'h300) $display("FAIL m3_r14: got %h exp 300", o_rm_reg); else pass_cnt++;
    endtask

    task automatic test_en_hold();
        i_exc_req = 1'b1; i_exc_mode = 2'd1; i_exc_ret_addr = 32'h55;
        tick();
        total_cnt++; if (o_exc_ack !== 1'b1) $display("FAIL hold_ack: got %0b exp 1", o_exc_ack); else pass_cnt++;
        i_exc_req = 1'b0;
        en = 1'b0;
        i_rd_en_ex = 1'b1; i_rd_code_ex = 4'd5; i_rd_reg_ex = 32'h5;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if ({o_exc_ack, o_busy, o_mode} !== 4'b01_11)
                $display("FAIL en_hold_%0d: got %b exp 0111", i, {o_exc_ack, o_busy, o_mode});
            else pass_cnt++;
        end
        en = 1'b1;
        i_rd_en_ex = 1'b0;
        tick();
        set_reads(4'd5, 4'd13, 4'd14, 4'd15);
        total_cnt++; if ({o_busy, o_mode} !== 3'b0_01) $display("FAIL hold_done: got %b exp 001", {o_busy, o_mode}); else pass_cnt++;
        total_cnt++; if (o_rm_reg !== 32'h0) $display("FAIL en0_no_write: got %h exp 0", o_rm_reg); else pass_cnt++;
        total_cnt++; if (o_rs_reg !== 32'h55) $display("FAIL m1_r14_new: got %h exp 55", o_rs_reg); else pass_cnt++;
    endtask

    task automatic test_reset_mid_enter();
        i_exc_req = 1'b1; i_exc_mode = 2'd2; i_exc_ret_addr = 32'h66;
        tick();
        i_exc_req = 1'b0;
        total_cnt++; if (o_busy !== 1'b1) $display("FAIL mid_busy: got %0b exp 1", o_busy); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_reads(4'd3, 4'd13, 4'd14, 4'd15);
        total_cnt++; if ({o_exc_ack, o_busy, o_mode} !== 4'b00_00) $display("FAIL mid_rst_state: got %b exp 0000", {o_exc_ack, o_busy, o_mode}); else pass_cnt++;
        total_cnt++; if ({o_rm_reg, o_rn_reg, o_rs_reg} !== 96'h0) $display("FAIL mid_rst_regs: got %h %h %h exp 0", o_rm_reg, o_rn_reg, o_rs_reg); else pass_cnt++;
        total_cnt++; if (o_re_reg !== 32'hCAFE_0000) $display("FAIL mid_rst_r15: got %h exp cafe0000", o_re_reg); else pass_cnt++;
        set_reads(4'd12, 4'd1, 4'd14, 4'd15);
        total_cnt++; if ({o_rm_reg, o_rn_reg} !== 64'h0) $display("FAIL mid_rst_r12_r1: got %h %h exp 0", o_rm_reg, o_rn_reg); else pass_cnt++;
        tick();
        total_cnt++; if ({o_busy, o_mode} !== 3'b0_00) $display("FAIL mid_rst_after: got %b exp 000", {o_busy, o_mode}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_priority();
        test_pc_write();
        test_enter();
        test_nested();
        test_ret_mode0();
        test_back_to_back();
        test_en_hold();
        test_reset_mid_enter();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
